// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared types and constants for the CDB writeback arbiter: source IDs,
// entry field widths and the buffered entry layouts.
package cdb_writeback_arbiter_pkg;

    localparam int DATA_LEN      = 32;
    localparam int RRF_SEL       = 6;
    localparam int ADDR_LEN      = 32;
    localparam int CDB_SRC_WIDTH = 2;

    localparam logic [CDB_SRC_WIDTH-1:0] CDB_SRC_ALU    = 2'd0;
    localparam logic [CDB_SRC_WIDTH-1:0] CDB_SRC_BRANCH = 2'd1;
    localparam logic [CDB_SRC_WIDTH-1:0] CDB_SRC_MEM    = 2'd2;

    typedef struct packed {
        logic                rrf_we;
        logic [RRF_SEL-1:0]  tag;
        logic [DATA_LEN-1:0] data;
    } wb_entry_t;

    // Only the branch FIFO carries the redirect fields.
    typedef struct packed {
        wb_entry_t           base;
        logic                if_jump;
        logic [ADDR_LEN-1:0] jump_addr;
    } wb_br_entry_t;

    function automatic logic [CDB_SRC_WIDTH-1:0] next_src(input logic [CDB_SRC_WIDTH-1:0] s);
        return (s == CDB_SRC_MEM) ? CDB_SRC_ALU : s + 2'd1;
    endfunction

endpackage

// File: rtl/cdb_writeback_arbiter_fifo.sv
// Per-source writeback FIFO. A push into a full FIFO lands only when the
// same cycle also pops; otherwise it is dropped and the caller flags it.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Writeback stage: buffers ALU/Branch/Mem completions per source and
// round-robins them onto a registered common data bus.
module cdb_writeback_arbiter
    import cdb_writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     alu_rob_we_i,
    input  logic                     alu_rrf_we_i,
    input  logic [RRF_SEL-1:0]       alu_rrf_tag_i,
    input  logic [DATA_LEN-1:0]      alu_result_i,
    input  logic                     branch_rob_we_i,
    input  logic                     branch_rrf_we_i,
    input  logic [RRF_SEL-1:0]       branch_rrf_tag_i,
    input  logic [DATA_LEN-1:0]      branch_result_i,
    input  logic                     branch_if_jump_i,
    input  logic [ADDR_LEN-1:0]      branch_jump_addr_i,
    input  logic                     mem_rob_we_i,
    input  logic                     mem_rrf_we_i,
    input  logic [RRF_SEL-1:0]       mem_rrf_tag_i,
    input  logic [DATA_LEN-1:0]      mem_result_i,
    output logic                     cdb_valid_o,
    output logic                     cdb_rrf_we_o,
    output logic [RRF_SEL-1:0]       cdb_rrf_tag_o,
    output logic [DATA_LEN-1:0]      cdb_data_o,
    output logic [CDB_SRC_WIDTH-1:0] cdb_src_o,
    output logic                     cdb_if_jump_o,
    output logic [ADDR_LEN-1:0]      cdb_jump_addr_o,
    output logic                     stall_alu_o,
    output logic                     stall_branch_o,
    output logic                     stall_mem_o,
    output logic                     overflow_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_THR = CW'(FIFO_DEPTH - STALL_MARGIN);

    wb_entry_t    alu_din, alu_head, mem_din, mem_head;
    wb_br_entry_t br_din, br_head;
    logic         alu_empty, alu_full, br_empty, br_full, mem_empty, mem_full;
    logic [CW-1:0] alu_count, br_count, mem_count;
    logic         pop_alu, pop_br, pop_mem;

    logic [CDB_SRC_WIDTH-1:0] rr_ptr;
    logic [CDB_SRC_WIDTH-1:0] winner;
    logic [CDB_SRC_WIDTH-1:0] cand;
    logic [2:0]               nonempty;
    logic                     grant;
    logic                     ovf_hit;

    wb_entry_t                sel_entry;
    logic                     sel_jump;
    logic [ADDR_LEN-1:0]      sel_addr;

    assign alu_din = '{rrf_we: alu_rrf_we_i, tag: alu_rrf_tag_i, data: alu_result_i};
    assign mem_din = '{rrf_we: mem_rrf_we_i, tag: mem_rrf_tag_i, data: mem_result_i};
    assign br_din  = '{base: '{rrf_we: branch_rrf_we_i, tag: branch_rrf_tag_i, data: branch_result_i},
                       if_jump: branch_if_jump_i, jump_addr: branch_jump_addr_i};

    wb_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_i(clk_i), .reset_i(reset_i), .push(alu_rob_we_i), .pop(pop_alu),
        .din(alu_din), .dout(alu_head), .empty(alu_empty), .full(alu_full), .count(alu_count)
    );

    wb_fifo #(.WIDTH($bits(wb_br_entry_t)), .DEPTH(FIFO_DEPTH)) u_br_fifo (
        .clk_i(clk_i), .reset_i(reset_i), .push(branch_rob_we_i), .pop(pop_br),
        .din(br_din), .dout(br_head), .empty(br_empty), .full(br_full), .count(br_count)
    );

    wb_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk_i(clk_i), .reset_i(reset_i), .push(mem_rob_we_i), .pop(pop_mem),
        .din(mem_din), .dout(mem_head), .empty(mem_empty), .full(mem_full), .count(mem_count)
    );

    assign nonempty = {!mem_empty, !br_empty, !alu_empty};

    // Search three slots starting at rr_ptr; the first non-empty one wins.
    always_comb begin
        grant  = 1'b0;
        winner = rr_ptr;
        cand   = rr_ptr;
        for (int i = 0; i < 3; i++) begin
            if (!grant && nonempty[cand]) begin
                grant  = 1'b1;
                winner = cand;
            end
            cand = next_src(cand);
        end
    end

    assign pop_alu = grant && (winner == CDB_SRC_ALU);
    assign pop_br  = grant && (winner == CDB_SRC_BRANCH);
    assign pop_mem = grant && (winner == CDB_SRC_MEM);

    always_comb begin
        sel_entry = '0;
        sel_jump  = 1'b0;
        sel_addr  = '0;
        if (grant) begin
            case (winner)
                CDB_SRC_ALU:    sel_entry = alu_head;
                CDB_SRC_BRANCH: begin
                    sel_entry = br_head.base;
                    sel_jump  = br_head.if_jump;
                    sel_addr  = br_head.jump_addr;
                end
                CDB_SRC_MEM:    sel_entry = mem_head;
                default:        sel_entry = '0;
            endcase
        end
    end

    // A full FIFO only accepts a push when it is also the winner this cycle.
    assign ovf_hit = (alu_rob_we_i    && alu_full && !pop_alu) ||
                     (branch_rob_we_i && br_full  && !pop_br)  ||
                     (mem_rob_we_i    && mem_full && !pop_mem);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr          <= CDB_SRC_ALU;
            cdb_valid_o     <= 1'b0;
            cdb_rrf_we_o    <= 1'b0;
            cdb_rrf_tag_o   <= '0;
            cdb_data_o      <= '0;
            cdb_src_o       <= '0;
            cdb_if_jump_o   <= 1'b0;
            cdb_jump_addr_o <= '0;
            overflow_o      <= 1'b0;
        end else begin
            if (grant) rr_ptr <= next_src(winner);
            cdb_valid_o     <= grant;
            cdb_rrf_we_o    <= sel_entry.rrf_we;
            cdb_rrf_tag_o   <= sel_entry.tag;
            cdb_data_o      <= sel_entry.data;
            cdb_src_o       <= grant ? winner : '0;
            cdb_if_jump_o   <= sel_jump;
            cdb_jump_addr_o <= sel_addr;
            overflow_o      <= overflow_o | ovf_hit;
        end
    end

    assign stall_alu_o    = (alu_count >= STALL_THR);
    assign stall_branch_o = (br_count  >= STALL_THR);
    assign stall_mem_o    = (mem_count >= STALL_THR);

endmodule
